// File: rtl/rx_fsm_16bit.sv
// rx_fsm_16bit: oversampling serial receiver for the 16:1 bit-select serializer.
// Frame: start (0), 16 data bits LSB first, optional even-parity bit, stop (1).
// Optional feature macro: RX_PARITY_CHECK_EN adds a PARITY state and the
// parity_error output; without it the frame is exactly 18 bits.
// TICKS_PER_BIT must be an even number of at least 4.

module rx_fsm_16bit #(
  parameter int Q             = 1,
  parameter int TICKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sample_tick,
  input  logic [Q-1:0]    serial_in,
  output logic [16*Q-1:0] data_out,
  output logic            data_valid,
  output logic            busy,
  output logic            frame_error,
`ifdef RX_PARITY_CHECK_EN
  output logic            parity_error,
`endif
  output logic [3:0]      bit_index
);

  localparam int CW = $clog2(TICKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(TICKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(TICKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RX_PARITY_CHECK_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   tick_cnt, tick_next;
  logic [3:0]      bit_next;
  logic [16*Q-1:0] shift_reg, shift_next;
  logic [16*Q-1:0] data_out_next;
  logic            valid_next;
  logic            ferr_next;

`ifdef RX_PARITY_CHECK_EN
  logic parity_bad, parity_bad_next;
  logic perr_next;
  logic lane0_xor;

  // XOR of the 16 lane-0 data bits already held in the shift register
  always_comb begin
    lane0_xor = 1'b0;
    for (int i = 0; i < 16; i++) begin
      lane0_xor = lane0_xor ^ shift_reg[i*Q];
    end
  end
`endif

  assign busy = (state != IDLE);

  // State, counters, shift register and output pulses all register here
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_index   <= '0;
      shift_reg   <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
      parity_bad   <= 1'b0;
      parity_error <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      tick_cnt    <= tick_next;
      bit_index   <= bit_next;
      shift_reg   <= shift_next;
      data_out    <= data_out_next;
      data_valid  <= valid_next;
      frame_error <= ferr_next;
`ifdef RX_PARITY_CHECK_EN
      parity_bad   <= parity_bad_next;
      parity_error <= perr_next;
`endif
    end
  end

  // Next-state logic; everything holds unless sample_tick is high, pulses default low
  always_comb begin
    state_next    = state;
    tick_next     = tick_cnt;
    bit_next      = bit_index;
    shift_next    = shift_reg;
    data_out_next = data_out;
    valid_next    = 1'b0;
    ferr_next     = 1'b0;
`ifdef RX_PARITY_CHECK_EN
    parity_bad_next = parity_bad;
    perr_next       = 1'b0;
`endif
    if (sample_tick) begin
      case (state)
        IDLE: begin
          if (!serial_in[0]) begin
            state_next = START;
            tick_next  = '0;
          end
        end
        START: begin
          if (tick_cnt == HALF_LAST) begin
            tick_next = '0;
            if (!serial_in[0]) begin
              state_next = DATA;
              bit_next   = 4'd0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            tick_next = tick_cnt + CW'(1);
          end
        end
        DATA: begin
          if (tick_cnt == BIT_LAST) begin
            tick_next = '0;
            shift_next[bit_index*Q +: Q] = serial_in;
            if (bit_index == 4'd15) begin
`ifdef RX_PARITY_CHECK_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              bit_next = bit_index + 4'd1;
            end
          end else begin
            tick_next = tick_cnt + CW'(1);
          end
        end
`ifdef RX_PARITY_CHECK_EN
        PARITY: begin
          if (tick_cnt == BIT_LAST) begin
            tick_next       = '0;
            parity_bad_next = lane0_xor ^ serial_in[0];
            state_next      = STOP;
          end else begin
            tick_next = tick_cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (tick_cnt == BIT_LAST) begin
            tick_next = '0;
            if (serial_in[0]) begin
              state_next = IDLE;
`ifdef RX_PARITY_CHECK_EN
              if (parity_bad) begin
                perr_next = 1'b1;
              end else begin
                data_out_next = shift_reg;
                valid_next    = 1'b1;
              end
`else
              data_out_next = shift_reg;
              valid_next    = 1'b1;
`endif
            end else begin
              ferr_next  = 1'b1;
              state_next = WAIT_IDLE;
            end
          end else begin
            tick_next = tick_cnt + CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (serial_in[0]) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule
